// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory access path: access size codes,
// access FSM state encoding, big-endian byte-lane positions and alignment helpers.
package mips_mem_pkg;

   // Access size codes as presented on Req_size
   localparam logic [1:0] SIZE_BYTE     = 2'b00;
   localparam logic [1:0] SIZE_HALF     = 2'b01;
   localparam logic [1:0] SIZE_WORD     = 2'b10;
   localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_CAP  = 2'b10,
      ST_WR   = 2'b11
   } state_t;

   // Big-endian lane positions: offset 0 lives in the most significant lane
   localparam logic [4:0] BYTE0_LSB = 5'd24;
   localparam logic [4:0] BYTE1_LSB = 5'd16;
   localparam logic [4:0] BYTE2_LSB = 5'd8;
   localparam logic [4:0] BYTE3_LSB = 5'd0;
   localparam logic [4:0] HALF0_LSB = 5'd16;
   localparam logic [4:0] HALF1_LSB = 5'd0;

   // Right-justified lane masks
   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

   // Size code 11 behaves as a full word
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   // Halves need an even address, words a multiple of four; bytes never fault
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = offset[0];
         default:   bad = (offset != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a 32-bit memory word and a sub-word
// access: extracts and extends load lanes, merges store lanes into the old word.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] mem_word_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_word_o
);

   logic [4:0]  lane_lsb_s;
   logic [31:0] lane_mask_s;
   logic [31:0] shifted_s;
   logic        sign_s;

   // Pick the bit position and width of the addressed lane
   always_comb begin
      lane_lsb_s  = 5'd0;
      lane_mask_s = WORD_MASK;
      case (size_i)
         SIZE_BYTE: begin
            lane_mask_s = BYTE_MASK;
            case (offset_i)
               2'd0:    lane_lsb_s = BYTE0_LSB;
               2'd1:    lane_lsb_s = BYTE1_LSB;
               2'd2:    lane_lsb_s = BYTE2_LSB;
               default: lane_lsb_s = BYTE3_LSB;
            endcase
         end
         SIZE_HALF: begin
            lane_mask_s = HALF_MASK;
            if (offset_i[1]) begin
               lane_lsb_s = HALF1_LSB;
            end else begin
               lane_lsb_s = HALF0_LSB;
            end
         end
         default: begin
            lane_lsb_s  = 5'd0;
            lane_mask_s = WORD_MASK;
         end
      endcase
   end

   // Right-justify and extend the load lane; splice the store lane into the old word
   always_comb begin
      shifted_s = mem_word_i >> lane_lsb_s;
      sign_s    = 1'b0;
      if (signed_i) begin
         if (size_i == SIZE_BYTE) begin
            sign_s = shifted_s[7];
         end else if (size_i == SIZE_HALF) begin
            sign_s = shifted_s[15];
         end else begin
            sign_s = 1'b0;
         end
      end else begin
         sign_s = 1'b0;
      end
      load_data_o   = (shifted_s & lane_mask_s) | ({32{sign_s}} & ~lane_mask_s);
      merged_word_o = (mem_word_i & ~(lane_mask_s << lane_lsb_s))
                    | ((store_data_i & lane_mask_s) << lane_lsb_s);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a requester and a word-wide synchronous data
// memory. Sub-word stores are done as read-modify-write; all memory and
// response outputs are registered.
module mem_access_unit
   import mips_mem_pkg::*;
(
   input  logic        Clk,
   input  logic        rst,
   input  logic        Req_valid,
   output logic        Req_ready,
   input  logic        Req_wr,
   input  logic [1:0]  Req_size,
   input  logic        Req_signed,
   input  logic [31:0] Req_addr,
   input  logic [31:0] Req_wdata,
   output logic        Resp_valid,
   output logic [31:0] Resp_rdata,
   output logic        Addr_err,
   output logic [31:0] Mem_Addr,
   output logic [31:0] Mem_Data_out,
   input  logic [31:0] Mem_Data_in,
   output logic        Mem_We
);

   state_t      state_q, state_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_dout_q, mem_dout_d;
   logic        mem_we_q, mem_we_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        addr_err_q, addr_err_d;

   // Request fields latched at acceptance for use in later states
   logic        lat_wr_q, lat_wr_d;
   logic [1:0]  lat_size_q, lat_size_d;
   logic        lat_signed_q, lat_signed_d;
   logic [1:0]  lat_off_q, lat_off_d;
   logic [31:0] lat_wdata_q, lat_wdata_d;

   logic [31:0] load_data_s;
   logic [31:0] merged_word_s;

   mem_lane_align u_lane_align (
      .size_i        (lat_size_q),
      .signed_i      (lat_signed_q),
      .offset_i      (lat_off_q),
      .mem_word_i    (Mem_Data_in),
      .store_data_i  (lat_wdata_q),
      .load_data_o   (load_data_s),
      .merged_word_o (merged_word_s)
   );

   assign Req_ready    = (state_q == ST_IDLE);
   assign Mem_Addr     = mem_addr_q;
   assign Mem_Data_out = mem_dout_q;
   assign Mem_We       = mem_we_q;
   assign Resp_valid   = resp_valid_q;
   assign Resp_rdata   = resp_rdata_q;
   assign Addr_err     = addr_err_q;

   // Next-state and registered-output decode; Mem_We is low only for the WR cycle
   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      mem_dout_d   = mem_dout_q;
      mem_we_d     = 1'b1;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      addr_err_d   = 1'b0;
      lat_wr_d     = lat_wr_q;
      lat_size_d   = lat_size_q;
      lat_signed_d = lat_signed_q;
      lat_off_d    = lat_off_q;
      lat_wdata_d  = lat_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (Req_valid) begin
               if (is_misaligned(Req_size, Req_addr[1:0])) begin
                  // Fault completes from IDLE without touching memory
                  resp_valid_d = 1'b1;
                  addr_err_d   = 1'b1;
                  resp_rdata_d = 32'h0000_0000;
               end else begin
                  mem_addr_d   = {2'b00, Req_addr[31:2]};
                  lat_wr_d     = Req_wr;
                  lat_size_d   = Req_size;
                  lat_signed_d = Req_signed;
                  lat_off_d    = Req_addr[1:0];
                  lat_wdata_d  = Req_wdata;
                  if (Req_wr && is_word(Req_size)) begin
                     state_d    = ST_WR;
                     mem_dout_d = Req_wdata;
                     mem_we_d   = 1'b0;
                  end else begin
                     state_d = ST_RD;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
         end
         ST_CAP: begin
            if (lat_wr_q) begin
               state_d    = ST_WR;
               mem_dout_d = merged_word_s;
               mem_we_d   = 1'b0;
            end else begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data_s;
            end
         end
         ST_WR: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0000_0000;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, output and request-latch registers; reset abandons any access in flight
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= 32'h0000_0000;
         mem_dout_q   <= 32'h0000_0000;
         mem_we_q     <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         addr_err_q   <= 1'b0;
         lat_wr_q     <= 1'b0;
         lat_size_q   <= 2'b00;
         lat_signed_q <= 1'b0;
         lat_off_q    <= 2'b00;
         lat_wdata_q  <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_dout_q   <= mem_dout_d;
         mem_we_q     <= mem_we_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         addr_err_q   <= addr_err_d;
         lat_wr_q     <= lat_wr_d;
         lat_size_q   <= lat_size_d;
         lat_signed_q <= lat_signed_d;
         lat_off_q    <= lat_off_d;
         lat_wdata_q  <= lat_wdata_d;
      end
   end

endmodule
